// File: rtl/anim_sequencer.sv
// Frame-index sequencer for the 7-segment digit and animation decoders.
// Steps on a prescaled tick while running, or on a step_req edge while paused.
module anim_sequencer #(
    parameter int unsigned TICK_DIV = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] mode_sel,
    input  logic [1:0] speed,
    input  logic       run,
    input  logic       dir,
    input  logic       step_req,
    output logic [3:0] counter,
    output logic [2:0] mode,
    output logic       step,
    output logic       wrap
);

    localparam int unsigned PW = 24;

    logic [PW-1:0] presc_q, presc_d;
    logic [PW-1:0] period_m1;
    logic [3:0]    cnt_q, cnt_d;
    logic [2:0]    mode_q, mode_d;
    logic          step_q, step_d;
    logic          wrap_q, wrap_d;
    logic          hist_q, hist_d;
    logic          man_q, man_d;
    logic          arm_q;
    logic [2:0]    mode_req;
    logic [3:0]    len_m1;
    logic          tick;
    logic          advance;
    logic          mode_chg;

    assign period_m1 = (PW'(TICK_DIV) >> speed) - 24'd1;

    always_comb begin
        mode_req = (mode_sel == 3'd7) ? 3'd0 : mode_sel;
        unique case (mode_q)
            3'd0:                   len_m1 = 4'd9;
            3'd1, 3'd2, 3'd3, 3'd4: len_m1 = 4'd6;
            default:                len_m1 = 4'd5;
        endcase
        tick     = run && (presc_q >= period_m1);
        advance  = tick || man_q;
        mode_chg = (mode_req != mode_q);
    end

    always_comb begin
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        presc_d = run ? (tick ? '0 : presc_q + 24'd1) : '0;
        hist_d  = step_req;
        // arm_q masks a button already held high when reset is released
        man_d   = step_req && !hist_q && arm_q && !run;

        if (mode_chg) begin
            mode_d  = mode_req;
            cnt_d   = '0;
            presc_d = '0;
        end else if (advance) begin
            step_d = 1'b1;
            if (dir) begin
                wrap_d = (cnt_q == 4'd0);
                cnt_d  = wrap_d ? len_m1 : cnt_q - 4'd1;
            end else begin
                wrap_d = (cnt_q == len_m1);
                cnt_d  = wrap_d ? 4'd0 : cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            hist_q  <= 1'b0;
            man_q   <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
            hist_q  <= hist_d;
            man_q   <= man_d;
            arm_q   <= 1'b1;
        end
    end

    assign counter = cnt_q;
    assign mode    = mode_q;
    assign step    = step_q;
    assign wrap    = wrap_q;

endmodule
